// File: rtl/uart_relay_fifo.sv
// uart_relay_fifo: byte FIFO plus launch sequencer between uart_rx_sol and
// uart_tx_sol. Bytes leave in arrival order. Each launch is a single tx_en
// pulse, and the next launch waits until the transmitter is ready again.
//
// Optional build macro RELAY_LATENCY_EN adds a 32-bit arm-to-first-push
// latency counter on lat_cycles. When the macro is not defined,
// lat_cycles is tied to 0 and arm is ignored.
module uart_relay_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          flush,
  input  logic          arm,
  input  logic          tx_rdy,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [31:0]   lat_cycles
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  TMO_MAX  = 8'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_RDY  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      tmo, tmo_nx;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, launch;

  // empty/full come only from the registered count. Both flags therefore
  // always agree with count, and a pop in the same cycle never makes room
  // for a push.
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A push is accepted only when there is room and no flush is in progress.
  // Flush takes priority over a push in the same cycle.
  assign push = in_valid && !full && !flush;

  // Sequencer next-state logic. A launch is decided in S_IDLE from the
  // registered occupancy. The FSM then waits for tx_rdy to drop, or times
  // out if the transmitter never shows busy.
  always_comb begin
    state_nx = state;
    tmo_nx   = tmo;
    launch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && tx_rdy && !flush) begin
          launch   = 1'b1;
          tmo_nx   = '0;
          state_nx = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_rdy) begin
          state_nx = S_WAIT_RDY;
        end else begin
          tmo_nx = tmo + 8'd1;
          if (tmo + 8'd1 == TMO_MAX) state_nx = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        if (tx_rdy) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer state register. Flush does not touch it, so a launch that is
  // already in flight completes its wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmo   <= '0;
    end else begin
      state <= state_nx;
      tmo   <= tmo_nx;
    end
  end

  // Byte storage. Only accepted pushes are written.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  // Transmit handoff. tx_en is a one-cycle pulse. tx_data keeps the last
  // launched byte until the next launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_en <= launch;
      if (launch) tx_data <= mem[rd_ptr];
    end
  end

`ifdef RELAY_LATENCY_EN
  logic [31:0] lat_cnt;
  logic        lat_run;

  // Arm-to-first-push latency. The edge that accepts the freezing push
  // still counts. The counter saturates instead of wrapping. If arm and a
  // push arrive in the same cycle, the counter restarts and keeps running.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
      lat_run <= 1'b0;
    end else if (arm) begin
      lat_cnt <= '0;
      lat_run <= 1'b1;
    end else if (lat_run) begin
      if (lat_cnt != 32'hFFFF_FFFF) lat_cnt <= lat_cnt + 32'd1;
      if (push) lat_run <= 1'b0;
    end
  end

  assign lat_cycles = lat_cnt;
`else
  logic unused_arm;
  assign unused_arm = arm;
  assign lat_cycles = '0;
`endif

endmodule

// File: tb/tb_uart_relay_fifo.sv
// Bench for uart_relay_fifo. It uses directed table vectors, hand-written
// corner sequences and a randomized phase. A queue-based FIFO model checks
// order, drops, occupancy and the overflow flag. A simple transmitter model
// drives tx_rdy (it goes low for a random frame after each tx_en).
module tb_uart_relay_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int BT    = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, arm, tx_rdy;
  logic [7:0]  in_data;
  logic        tx_en, empty, full, overflow;
  logic [7:0]  tx_data;
  logic [AW:0] count;
  logic [31:0] lat_cycles;

  uart_relay_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .arm(arm), .tx_rdy(tx_rdy), .tx_en(tx_en),
    .tx_data(tx_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .lat_cycles(lat_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO reference model and transmitter model state
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] rx_q[$];
  bit         tx_real = 1'b0;
  int         busy = 0;
  int         n_en = 0;

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       fl;
    logic       rdy;
    int         e_cnt;
    logic       e_full;
    logic       e_ovf;
    logic       e_en;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mkv(logic v, logic [7:0] d, logic f, logic r,
                               int c, logic fu, logic ov, logic en, logic [7:0] ed);
    vec_t x;
    x.vld = v; x.dat = d; x.fl = f; x.rdy = r;
    x.e_cnt = c; x.e_full = fu; x.e_ovf = ov; x.e_en = en; x.e_dat = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // One clock. The task samples #1 after the edge, then updates the
  // reference model with the inputs that were present at the edge, and
  // finally advances the transmitter model.
  task automatic tick();
    logic p_rdy, p_vld, p_fl, p_rst;
    logic [7:0] p_dat;
    int occ;
    p_rdy = tx_rdy; p_vld = in_valid; p_fl = flush; p_rst = rst; p_dat = in_data;
    @(posedge clk);
    #1;
    if (p_rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (p_fl) begin
      chk("flush_no_launch", 32'(tx_en), 32'd0);
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      occ = mq.size();
      if (tx_en) begin
        n_en++;
        chk("launch_rdy_high", 32'(p_rdy), 32'd1);
        chk("launch_nonempty", 32'(occ > 0), 32'd1);
        if (occ > 0) chk("tx_data_order", 32'(tx_data), 32'(mq.pop_front()));
      end
      if (p_vld) begin
        if (occ < DEPTH) mq.push_back(p_dat);
        else m_ovf = 1'b1;
      end
    end
    if (!p_rst) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (tx_real) begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) tx_rdy = 1'b1;
      end
      if (tx_en) begin
        rx_q.push_back(tx_data);
        busy = $urandom_range(1, 6);
        tx_rdy = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input logic rdy, input bit real_tx);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; arm = 1'b0; in_data = 8'h00;
    tx_real = real_tx; busy = 0; tx_rdy = rdy;
    tick(); tick();
    rst = 1'b0;
    rx_q.delete();
    n_en = 0;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int want, input int budget);
    int k;
    k = 0;
    while ((rx_q.size() < want || count != 0) && k < budget) begin
      tick(); k++;
    end
    repeat (20) tick();
  endtask

  initial begin
    int first_en;

    // ---- reset state
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; arm = 1'b0; in_data = 8'h00; tx_rdy = 1'b1;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_lat", lat_cycles, 32'd0);

    // ---- table: fill 5, flush together with a push of 0x55, then one
    // push with tx_rdy high. That byte launches one cycle after it is counted.
    tbl[0] = mkv(1'b1, 8'h10, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[1] = mkv(1'b1, 8'h11, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[2] = mkv(1'b1, 8'h12, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[3] = mkv(1'b1, 8'h13, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[4] = mkv(1'b1, 8'h14, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[5] = mkv(1'b1, 8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[6] = mkv(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[7] = mkv(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[8] = mkv(1'b1, 8'h77, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[9] = mkv(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h77);
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].vld; in_data = tbl[i].dat; flush = tbl[i].fl; tx_rdy = tbl[i].rdy;
      tick();
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_full", 32'(full), 32'(tbl[i].e_full));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[i].e_ovf));
      chk("tbl_tx_en", 32'(tx_en), 32'(tbl[i].e_en));
      chk("tbl_tx_data", 32'(tx_data), 32'(tbl[i].e_dat));
    end
    in_valid = 1'b0; flush = 1'b0;

    // ---- three bytes through a transmitter that really goes busy
    do_reset(1'b1, 1'b1);
    push(8'h41); push(8'h42); push(8'h43);
    drain(3, 300);
    chk("t1_nbytes", 32'(rx_q.size()), 32'd3);
    chk("t1_en_pulses", 32'(n_en), 32'd3);
    chk("t1_count", 32'(count), 32'd0);
    if (rx_q.size() == 3) begin
      chk("t1_b0", 32'(rx_q[0]), 32'h41);
      chk("t1_b1", 32'(rx_q[1]), 32'h42);
      chk("t1_b2", 32'(rx_q[2]), 32'h43);
    end

    // ---- 18 pushes while the transmitter is held busy: 16 kept, 2 dropped
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 18; i++) push(8'hA0 + 8'(i));
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_ovf", 32'(overflow), 32'd1);
    tx_real = 1'b1; busy = 0; tx_rdy = 1'b1; rx_q.delete(); n_en = 0;
    drain(16, 600);
    chk("t2_nbytes", 32'(rx_q.size()), 32'd16);
    chk("t2_en_pulses", 32'(n_en), 32'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk("t2_byte", 32'(rx_q[i]), 32'hA0 + 32'(i));

    // ---- launch latency, and the timeout path when tx_rdy never drops.
    // Byte accepted at edge 0 launches at edge 1. With rdy stuck high the
    // FSM spends BT edges in the busy wait, returns to idle, and launches
    // again at the following edge.
    do_reset(1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'h31;
    tick();
    chk("t3_no_en_edge0", 32'(tx_en), 32'd0);
    in_data = 8'h32;
    tick();
    in_valid = 1'b0;
    chk("t3_en_edge1", 32'(tx_en), 32'd1);
    chk("t3_data_edge1", 32'(tx_data), 32'h31);
    first_en = -1;
    for (int k = 2; k < 12 && first_en < 0; k++) begin
      tick();
      if (tx_en) first_en = k;
    end
    chk("t3_second_launch_edge", 32'(first_en), 32'(1 + BT + 1));
    chk("t3_second_data", 32'(tx_data), 32'h32);

    // ---- full FIFO: pop and push in the same cycle, then flush clears the
    // sticky flag
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_ovf0", 32'(overflow), 32'd0);
    tx_rdy = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    tx_rdy = 1'b0; in_valid = 1'b0;
    chk("t5_pop_en", 32'(tx_en), 32'd1);
    chk("t5_pop_data", 32'(tx_data), 32'h60);
    chk("t5_count", 32'(count), 32'd15);
    chk("t5_ovf", 32'(overflow), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_count", 32'(count), 32'd0);
    chk("t5_flush_ovf", 32'(overflow), 32'd0);
    chk("t5_flush_empty", 32'(empty), 32'd1);

    // ---- latency counter
    do_reset(1'b0, 1'b0);
`ifdef RELAY_LATENCY_EN
    arm = 1'b1; tick(); arm = 1'b0;
    chk("lat_armed", lat_cycles, 32'd0);
    repeat (99) tick();
    chk("lat_live99", lat_cycles, 32'd99);
    push(8'h01);
    chk("lat_frozen", lat_cycles, 32'd100);
    repeat (10) tick();
    push(8'h02);
    chk("lat_stays", lat_cycles, 32'd100);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("lat_rearm", lat_cycles, 32'd0);
    tick(); tick();
    chk("lat_rerun", lat_cycles, 32'd2);
    arm = 1'b1; in_valid = 1'b1; in_data = 8'h03; tick(); arm = 1'b0; in_valid = 1'b0;
    chk("lat_arm_push", lat_cycles, 32'd0);
    tick();
    chk("lat_not_frozen", lat_cycles, 32'd1);
    push(8'h04);
    tick();
    chk("lat_frozen2", lat_cycles, 32'd2);
`else
    arm = 1'b1; tick(); arm = 1'b0;
    push(8'h01);
    tick();
    chk("lat_off", lat_cycles, 32'd0);
`endif

    // ---- randomized traffic, with occasional flush and reset
    do_reset(1'b1, 1'b1);
    begin
      int rate;
      rate = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 200 == 0) begin
          case ($urandom_range(0, 2))
            0: rate = 15;
            1: rate = 55;
            default: rate = 95;
          endcase
        end
        in_valid = ($urandom_range(0, 99) < rate);
        in_data  = 8'($urandom);
        flush    = ($urandom_range(0, 249) == 0);
        rst      = ($urandom_range(0, 999) == 0);
        tick();
      end
      in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
      drain(0, 600);
      chk("rand_drained", 32'(count), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
